// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and a conditional two's-complement negate used for divide sign handling.
package muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    function automatic logic [31:0] md_cneg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_div_restoring.sv
// Iterative unsigned 32-bit restoring divider: one quotient bit per edge,
// 'last' is high during the cycle whose edge performs the final step.
module div_restoring #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam logic [5:0] LAST_CNT = 6'(ITERS - 1);

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic [5:0]  cnt_r;
    logic        run_r;
    logic [32:0] shifted_s;
    logic [32:0] diff_s;
    logic        fits_s;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        fits_s    = ~diff_s[32];
    end

    // Iteration state: load operands, then shift one bit in per edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dvs_r <= 32'd0;
            cnt_r <= 6'd0;
            run_r <= 1'b0;
        end else if (flush) begin
            run_r <= 1'b0;
        end else if (load) begin
            rem_r <= 32'd0;
            quo_r <= dividend;
            dvs_r <= divisor;
            cnt_r <= 6'd0;
            run_r <= 1'b1;
        end else if (run_r) begin
            rem_r <= fits_s ? diff_s[31:0] : shifted_s[31:0];
            quo_r <= {quo_r[30:0], fits_s};
            cnt_r <= cnt_r + 6'd1;
            run_r <= (cnt_r != LAST_CNT);
        end
    end

    assign last      = run_r && (cnt_r == LAST_CNT);
    assign quotient  = quo_r;
    assign remainder = rem_r;
endmodule

// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit owning HI/LO; multi-cycle ops raise busy so the
// pipeline stalls later HI/LO accesses until the result is written.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = MD_DIV_ITERS
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int         MUL_LOAD_I = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
    localparam logic [1:0] MUL_LOAD   = MUL_LOAD_I[1:0];

    md_state_e   state_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] prod_r;
    logic [1:0]  mul_cnt_r;
    logic        qneg_r;
    logic        rneg_r;
    logic        bzero_r;
    logic [31:0] a_orig_r;

    logic        accept_s;
    logic        mul_signed_s;
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] product_s;
    logic        div_signed_s;
    logic        sa_s;
    logic        sb_s;
    logic        div_load_s;
    logic [31:0] dvd_abs_s;
    logic [31:0] dvs_abs_s;
    logic        div_last_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;
    logic [31:0] q_fix_s;
    logic [31:0] r_fix_s;

    // Operand conditioning: one shared 64x64 product, divide magnitudes and signs
    always_comb begin
        accept_s     = bus.start && !bus.flush && (state_r == ST_IDLE);
        mul_signed_s = (bus.op == MD_MULT);
        mul_a_s      = {{32{mul_signed_s & bus.a[31]}}, bus.a};
        mul_b_s      = {{32{mul_signed_s & bus.b[31]}}, bus.b};
        product_s    = mul_a_s * mul_b_s;
        div_signed_s = (bus.op == MD_DIV);
        sa_s         = div_signed_s & bus.a[31];
        sb_s         = div_signed_s & bus.b[31];
        dvd_abs_s    = md_cneg(bus.a, sa_s);
        dvs_abs_s    = md_cneg(bus.b, sb_s);
        div_load_s   = accept_s && ((bus.op == MD_DIV) || (bus.op == MD_DIVU));
        q_fix_s      = md_cneg(div_quo_s, qneg_r);
        r_fix_s      = md_cneg(div_rem_s, rneg_r);
    end

    div_restoring #(.ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_load_s),
        .flush     (bus.flush),
        .dividend  (dvd_abs_s),
        .divisor   (dvs_abs_s),
        .last      (div_last_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Control FSM with registered busy/done and the architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            prod_r    <= 64'd0;
            mul_cnt_r <= 2'd0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            bzero_r   <= 1'b0;
            a_orig_r  <= 32'd0;
        end else begin
            done_r <= 1'b0;
            if (bus.flush) begin
                // Cancellation wins over both a new request and a pending write
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                MD_MULT, MD_MULTU: begin
                                    if (MUL_CYCLES == 1) begin
                                        hi_r   <= product_s[63:32];
                                        lo_r   <= product_s[31:0];
                                        done_r <= 1'b1;
                                    end else begin
                                        prod_r    <= product_s;
                                        mul_cnt_r <= MUL_LOAD;
                                        state_r   <= ST_MUL;
                                        busy_r    <= 1'b1;
                                    end
                                end
                                MD_DIV, MD_DIVU: begin
                                    qneg_r   <= sa_s ^ sb_s;
                                    rneg_r   <= sa_s;
                                    bzero_r  <= (bus.b == 32'd0);
                                    a_orig_r <= bus.a;
                                    state_r  <= ST_DIV;
                                    busy_r   <= 1'b1;
                                end
                                MD_MTHI: begin
                                    hi_r   <= bus.a;
                                    done_r <= 1'b1;
                                end
                                MD_MTLO: begin
                                    lo_r   <= bus.a;
                                    done_r <= 1'b1;
                                end
                                default: begin
                                    state_r <= ST_IDLE;
                                end
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (mul_cnt_r == 2'd0) begin
                            hi_r    <= prod_r[63:32];
                            lo_r    <= prod_r[31:0];
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            mul_cnt_r <= mul_cnt_r - 2'd1;
                        end
                    end
                    ST_DIV: begin
                        if (div_last_s) begin
                            state_r <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        // Divide by zero returns all-ones quotient and the raw dividend
                        if (bzero_r) begin
                            lo_r <= 32'hFFFF_FFFF;
                            hi_r <= a_orig_r;
                        end else begin
                            lo_r <= q_fix_s;
                            hi_r <= r_fix_s;
                        end
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, busy lengths,
// flush cancellation and ignored requests.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk;
    logic reset;
    int   total_cnt;
    int   bad_cnt;

    muldiv_unit_if bus_if ();

    muldiv_unit #(.MUL_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
        bus_if.start = 1'b1;
        bus_if.op    = o;
        bus_if.a     = xa;
        bus_if.b     = xb;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] xa,
                          input logic [31:0] xb, input int exp_busy,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int busy_n;
        int guard;
        busy_n = 0;
        guard  = 0;
        issue(o, xa, xb);
        while (!bus_if.done && guard < 100) begin
            if (bus_if.busy) busy_n++;
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_done_seen"}, {63'd0, bus_if.done}, 64'd1);
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check_eq({tag, "_hi"}, {32'd0, bus_if.hi}, {32'd0, ehi});
        check_eq({tag, "_lo"}, {32'd0, bus_if.lo}, {32'd0, elo});
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, {63'd0, bus_if.done}, 64'd0);
    endtask

    initial begin
        logic saw_done;
        int   guard;
        total_cnt    = 0;
        bad_cnt      = 0;
        reset        = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = 3'd0;
        bus_if.a     = 32'd0;
        bus_if.b     = 32'd0;
        bus_if.flush = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_hi", {32'd0, bus_if.hi}, 64'd0);
        check_eq("rst_lo", {32'd0, bus_if.lo}, 64'd0);
        check_eq("rst_busy", {63'd0, bus_if.busy}, 64'd0);
        check_eq("rst_done", {63'd0, bus_if.done}, 64'd0);

        run_op("mthi", MD_MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'h0000_0000);
        run_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negb", MD_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
        run_op("divu_z", MD_DIVU, 32'h0000_0055, 32'd0, 33, 32'h0000_0055, 32'hFFFF_FFFF);
        run_op("div_z", MD_DIV, 32'hFFFF_FF00, 32'd0, 33, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
        run_op("mtlo", MD_MTLO, 32'hCAFE_F00D, 32'd0, 0, 32'h0000_0000, 32'hCAFE_F00D);

        // Flush a divide on its 10th busy cycle
        run_op("pre_hi", MD_MTHI, 32'h0000_AAAA, 32'd0, 0, 32'h0000_AAAA, 32'hCAFE_F00D);
        run_op("pre_lo", MD_MTLO, 32'h0000_5555, 32'd0, 0, 32'h0000_AAAA, 32'h0000_5555);
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check_eq("fl_busy_before", {63'd0, bus_if.busy}, 64'd1);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check_eq("fl_busy_after", {63'd0, bus_if.busy}, 64'd0);
        saw_done = bus_if.done;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | bus_if.done;
        end
        check_eq("fl_no_done", {63'd0, saw_done}, 64'd0);
        check_eq("fl_hi", {32'd0, bus_if.hi}, 64'h0000_AAAA);
        check_eq("fl_lo", {32'd0, bus_if.lo}, 64'h0000_5555);
        run_op("fl_mult", MD_MULTU, 32'd3, 32'd5, 1, 32'd0, 32'd15);

        // Flush on the edge that would write a multiply result
        issue(MD_MULT, 32'd9, 32'd9);
        check_eq("flw_busy", {63'd0, bus_if.busy}, 64'd1);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check_eq("flw_busy_after", {63'd0, bus_if.busy}, 64'd0);
        check_eq("flw_done", {63'd0, bus_if.done}, 64'd0);
        check_eq("flw_lo", {32'd0, bus_if.lo}, 64'd15);

        // MTLO while a divide is busy is dropped
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        issue(MD_MTLO, 32'h0000_1111, 32'd0);
        guard = 0;
        while (!bus_if.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("bz_done_seen", {63'd0, bus_if.done}, 64'd1);
        check_eq("bz_lo", {32'd0, bus_if.lo}, 64'd14);
        check_eq("bz_hi", {32'd0, bus_if.hi}, 64'd2);
        repeat (3) @(negedge clk);
        check_eq("bz_lo_later", {32'd0, bus_if.lo}, 64'd14);

        // flush together with start in IDLE
        bus_if.flush = 1'b1;
        issue(MD_MTHI, 32'h0000_DEAD, 32'd0);
        bus_if.flush = 1'b0;
        check_eq("fs_busy", {63'd0, bus_if.busy}, 64'd0);
        check_eq("fs_done", {63'd0, bus_if.done}, 64'd0);
        check_eq("fs_hi", {32'd0, bus_if.hi}, 64'd2);

        // Undefined op code
        issue(3'd7, 32'h0BAD_0BAD, 32'd1);
        check_eq("undef_busy", {63'd0, bus_if.busy}, 64'd0);
        check_eq("undef_done", {63'd0, bus_if.done}, 64'd0);
        check_eq("undef_hilo", {bus_if.hi, bus_if.lo}, {32'd2, 32'd14});

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
